// File: rtl/mips_fetch_pkg.sv
// Shared fetch-stage types: word width, default reset PC
// and the redirect kind selected for the consumed instruction.
package mips_fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    SEQ,
    BR,
    J,
    JR
  } redir_e;

endpackage

// File: rtl/next_pc_calc.sv
// Redirect selection and target arithmetic for the consumed instruction.
// Ports: pc_i (consumed PC), redirect requests/operands in, kind_o and target_o out.
module next_pc_calc
  import mips_fetch_pkg::*;
(
  input  logic [XLEN-1:0] pc_i,
  input  logic            branch_taken_i,
  input  logic [15:0]     branch_offset_i,
  input  logic            jump_i,
  input  logic [25:0]     jump_index_i,
  input  logic            jr_i,
  input  logic [XLEN-1:0] jr_target_i,
  output redir_e          kind_o,
  output logic [XLEN-1:0] target_o
);

  logic [XLEN-1:0] pc4;
  logic [XLEN-1:0] br_off;

  assign pc4    = pc_i + 32'd4;
  assign br_off = {{14{branch_offset_i[15]}}, branch_offset_i, 2'b00};

  always_comb begin
    kind_o = SEQ;
    if (jr_i) begin
      kind_o = JR;
    end else if (jump_i) begin
      kind_o = J;
    end else if (branch_taken_i) begin
      kind_o = BR;
    end
  end

  always_comb begin
    target_o = pc4;
    unique case (kind_o)
      BR:      target_o = pc4 + br_off;
      J:       target_o = {pc4[31:28], jump_index_i, 2'b00};
      // Word-align the register target.
      JR:      target_o = jr_target_i & ~32'h3;
      default: target_o = pc4;
    endcase
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, IF/ID register and redirect handling.
// Ports: clk/rst, stall/out_ready flow control, branch/jump/jr redirects,
// im_addr/im_instr memory port, out_valid/out_instr/out_pc/out_pc_plus4 to decode.
// Build option: BRANCH_DELAY_SLOT_EN keeps the instruction after a redirect.
module instruction_fetch
  import mips_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            out_ready,
  input  logic            branch_taken,
  input  logic [15:0]     branch_offset,
  input  logic            jump,
  input  logic [25:0]     jump_index,
  input  logic            jr,
  input  logic [XLEN-1:0] jr_target,
  output logic [XLEN-1:0] im_addr,
  input  logic [XLEN-1:0] im_instr,
  output logic            out_valid,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_plus4
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] opc_q, opc_d;
  logic            valid_q, valid_d;
`ifdef BRANCH_DELAY_SLOT_EN
  logic            pend_q, pend_d;
  logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
`endif

  logic            fire;
  logic            load;
  logic            redirect;
  redir_e          kind;
  logic [XLEN-1:0] target;

  assign im_addr      = pc_q;
  assign out_valid    = valid_q;
  assign out_instr    = instr_q;
  assign out_pc       = opc_q;
  assign out_pc_plus4 = opc_q + 32'd4;

  assign fire     = valid_q & out_ready;
  assign load     = ~stall & (~valid_q | out_ready);
  assign redirect = fire & (kind != SEQ);

  next_pc_calc u_calc (
    .pc_i           (opc_q),
    .branch_taken_i (branch_taken),
    .branch_offset_i(branch_offset),
    .jump_i         (jump),
    .jump_index_i   (jump_index),
    .jr_i           (jr),
    .jr_target_i    (jr_target),
    .kind_o         (kind),
    .target_o       (target)
  );

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    opc_d   = opc_q;
    valid_d = valid_q;
`ifdef BRANCH_DELAY_SLOT_EN
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
`endif

    if (load) begin
      instr_d = im_instr;
      opc_d   = pc_q;
      valid_d = 1'b1;
      pc_d    = pc_q + 32'd4;
    end else if (fire) begin
      valid_d = 1'b0;
    end

`ifdef BRANCH_DELAY_SLOT_EN
    if (redirect) begin
      if (load) begin
        // Word at old pc_q is the delay slot; fetch resumes at target.
        pc_d   = target;
        pend_d = 1'b0;
      end else begin
        // Decode drained under stall: remember target until next load.
        pend_d     = 1'b1;
        pend_tgt_d = target;
      end
    end else if (load && pend_q) begin
      pc_d   = pend_tgt_q;
      pend_d = 1'b0;
    end
`else
    if (redirect) begin
      // Squash the word fetched at old pc_q: leaves one bubble.
      pc_d    = target;
      instr_d = instr_q;
      opc_d   = opc_q;
      valid_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      opc_q      <= '0;
      valid_q    <= 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
`endif
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      opc_q      <= opc_d;
      valid_q    <= valid_d;
`ifdef BRANCH_DELAY_SLOT_EN
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
`endif
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus random traffic,
// with delivered PCs checked against a queue of expected fetch order.
module tb_instruction_fetch;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        out_ready;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        jump;
  logic [25:0] jump_index;
  logic        jr;
  logic [31:0] jr_target;
  logic [31:0] im_addr;
  logic [31:0] im_instr;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;

  int checks = 0;
  int errors = 0;

  logic [31:0] expq[$];
  logic [31:0] mp, mh, mt;
  logic [31:0] s_pc, s_instr, s_addr;

  instruction_fetch #(.RESET_PC(RPC)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .out_ready    (out_ready),
    .branch_taken (branch_taken),
    .branch_offset(branch_offset),
    .jump         (jump),
    .jump_index   (jump_index),
    .jr           (jr),
    .jr_target    (jr_target),
    .im_addr      (im_addr),
    .im_instr     (im_instr),
    .out_valid    (out_valid),
    .out_instr    (out_instr),
    .out_pc       (out_pc),
    .out_pc_plus4 (out_pc_plus4)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign im_instr = memw(im_addr);

  // Redirect target from the architectural rules, for consumed PC p.
  function automatic logic [31:0] model_tgt(input logic [31:0] p);
    logic [31:0] p4;
    int          so;
    p4 = p + 32'd4;
    if (jr) return jr_target & 32'hFFFF_FFFC;
    if (jump) return {p4[31:28], jump_index, 2'b00};
    so = int'($signed(branch_offset));
    return p4 + 32'(so * 4);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard: the queue holds PCs decode should see, in order.
  always @(negedge clk) begin
    if (rst) begin
      expq.delete();
      expq.push_back(RPC);
    end else if (out_valid && out_ready) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: got pc %h expected none", out_pc);
      end else begin
        mp = expq.pop_front();
        chk("sb_pc", out_pc, mp);
        chk("sb_instr", out_instr, memw(mp));
        chk("sb_plus4", out_pc_plus4, mp + 32'd4);
        if (expq.size() == 0) expq.push_back(mp + 32'd4);
        if (jr || jump || branch_taken) begin
          mt = model_tgt(mp);
`ifdef BRANCH_DELAY_SLOT_EN
          mh = expq[0];
          expq.delete();
          expq.push_back(mh);
          expq.push_back(mt);
`else
          expq.delete();
          expq.push_back(mt);
`endif
        end
      end
    end
  end

  task automatic clr_redir();
    branch_taken  = 1'b0;
    branch_offset = '0;
    jump          = 1'b0;
    jump_index    = '0;
    jr            = 1'b0;
    jr_target     = '0;
  endtask

  task automatic wait_pc(input logic [31:0] a, input string nm);
    int n;
    bit found;
    n = 0;
    found = 1'b0;
    while (!found && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (out_valid && out_pc == a) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s: got no pc %h within 200 cycles, last %h",
               nm, a, out_pc);
    end
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    @(posedge clk);
    #1;
    while (!out_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("wait_valid", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic one_redir();
    @(posedge clk);
    #1;
    clr_redir();
  endtask

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      stall         = ($urandom_range(0, 3) == 0);
      out_ready     = ($urandom_range(0, 3) != 0);
      jr            = ($urandom_range(0, 19) == 0);
      jump          = ($urandom_range(0, 19) == 0);
      branch_taken  = ($urandom_range(0, 9) == 0);
      branch_offset = 16'($urandom);
      jump_index    = 26'($urandom);
      jr_target     = $urandom;
    end
    @(posedge clk);
    #1;
    clr_redir();
    stall     = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    rst       = 1'b1;
    stall     = 1'b0;
    out_ready = 1'b1;
    clr_redir();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_addr", im_addr, RPC);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    rst = 1'b0;
    chk("pre_edge_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("first_valid", {31'd0, out_valid}, 32'd1);
    chk("first_pc", out_pc, RPC);
    chk("first_instr", out_instr, memw(RPC));
    chk("first_addr", im_addr, RPC + 32'd4);

    // Taken branch from 0x10, offset 3.
    wait_pc(32'h10, "reach_10");
    branch_taken  = 1'b1;
    branch_offset = 16'h0003;
    one_redir();
    chk("br_addr", im_addr, 32'h20);
`ifdef BRANCH_DELAY_SLOT_EN
    chk("br_delay_slot", out_pc, 32'h14);
`else
    chk("br_bubble", {31'd0, out_valid}, 32'd0);
`endif
    wait_pc(32'h20, "br_target");

    // Jump to 0x1C, then all three redirects at once.
    jump       = 1'b1;
    jump_index = 26'h7;
    one_redir();
    wait_pc(32'h1C, "reach_1c");
    jr            = 1'b1;
    jump          = 1'b1;
    branch_taken  = 1'b1;
    jr_target     = 32'h37;
    jump_index    = 26'hB;
    branch_offset = 16'h0001;
    one_redir();
    chk("jr_prio_addr", im_addr, 32'h34);
    wait_pc(32'h34, "jr_target");
    jump       = 1'b1;
    jump_index = 26'hB;
    one_redir();
    chk("jump_addr", im_addr, 32'h2C);
    wait_pc(32'h2C, "jump_target");

    // Decode back-pressure holds everything.
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    s_pc    = out_pc;
    s_instr = out_instr;
    s_addr  = im_addr;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("hold_pc", out_pc, s_pc);
      chk("hold_instr", out_instr, s_instr);
      chk("hold_addr", im_addr, s_addr);
    end
    out_ready = 1'b1;

    // Redirect while fetch is stalled.
    jump       = 1'b1;
    jump_index = 26'h4;
    one_redir();
    wait_pc(32'h10, "reach_10_again");
    stall         = 1'b1;
    branch_taken  = 1'b1;
    branch_offset = 16'h0003;
    one_redir();
    chk("stall_br_valid", {31'd0, out_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
`ifdef BRANCH_DELAY_SLOT_EN
    chk("stall_br_addr", im_addr, 32'h14);
    stall = 1'b0;
    wait_pc(32'h14, "pending_slot");
    wait_pc(32'h20, "pending_target");
`else
    chk("stall_br_addr", im_addr, 32'h20);
    stall = 1'b0;
    wait_pc(32'h20, "stall_target");
`endif

    // Sequential fetch across the top of the address space.
    jr        = 1'b1;
    jr_target = 32'hFFFF_FFFC;
    one_redir();
    wait_pc(32'hFFFF_FFFC, "reach_top");
    chk("wrap_addr", im_addr, 32'h0);
    wait_pc(32'h0, "wrap_pc");

    rand_cycles(3000);

    // Reset between edges while a redirect may be pending.
    wait_valid();
    stall         = 1'b1;
    branch_taken  = 1'b1;
    branch_offset = 16'h0040;
    one_redir();
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_addr", im_addr, RPC);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    stall = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_pc0", out_pc, RPC);
    @(posedge clk);
    #1;
    chk("post_rst_pc1", out_pc, RPC + 32'd4);
    chk("post_rst_addr", im_addr, RPC + 32'd8);

    rand_cycles(500);
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
